// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational RV32I ALU between two requesters. Arbitration is
// round-robin. At most one operation is accepted per cycle.
// Each requester has a one-entry response slot that captures alu_out, zero and
// the request tag. The slot is returned over a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   reqN_*                request handshake + opcode/func3/func7/op1/op2/tag
//   respN_*               response handshake + captured data/zero/tag
//   alu_*                 operands driven to / result taken from the ALU
//   grant_cnt             running count of accepted operations (wraps)
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [6:0]       req0_opcode,
  input  logic [2:0]       req0_func3,
  input  logic [6:0]       req0_func7,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [6:0]       req1_opcode,
  input  logic [2:0]       req1_func3,
  input  logic [6:0]       req1_func7,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_data,
  output logic             resp0_zero,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_data,
  output logic             resp1_zero,
  output logic [TAG_W-1:0] resp1_tag,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic [15:0]      grant_cnt
);

  logic             full0_r, full1_r;
  logic             ptr_r;
  logic [31:0]      data0_r, data1_r;
  logic             zero0_r, zero1_r;
  logic [TAG_W-1:0] tag0_r, tag1_r;
  logic [15:0]      cnt_r;
  logic             elig0_s, elig1_s;
  logic             grant0_s, grant1_s;

  // A requester may be served when its slot is free now or is being drained
  // in this same cycle.
  assign elig0_s = req0_valid & (~full0_r | resp0_ready);
  assign elig1_s = req1_valid & (~full1_r | resp1_ready);

  // Round-robin choice: ptr names the requester that wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      grant0_s = ~ptr_r;
      grant1_s = ptr_r;
    end else if (elig0_s) begin
      grant0_s = 1'b1;
    end else if (elig1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // ALU operand mux. An idle ALU sees all-zero inputs, so it produces 0.
  always_comb begin
    alu_opcode = 7'd0;
    alu_func3  = 3'd0;
    alu_func7  = 7'd0;
    alu_op1    = 32'd0;
    alu_op2    = 32'd0;
    case ({grant1_s, grant0_s})
      2'b01: begin
        alu_opcode = req0_opcode;
        alu_func3  = req0_func3;
        alu_func7  = req0_func7;
        alu_op1    = req0_op1;
        alu_op2    = req0_op2;
      end
      2'b10: begin
        alu_opcode = req1_opcode;
        alu_func3  = req1_func3;
        alu_func7  = req1_func7;
        alu_op1    = req1_op1;
        alu_op2    = req1_op2;
      end
      default: begin
        alu_opcode = 7'd0;
        alu_func3  = 3'd0;
        alu_func7  = 7'd0;
        alu_op1    = 32'd0;
        alu_op2    = 32'd0;
      end
    endcase
  end

  // Priority pointer moves to the loser after each grant. The counter counts grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
      cnt_r <= 16'd0;
    end else if (grant0_s) begin
      ptr_r <= 1'b1;
      cnt_r <= cnt_r + 16'd1;
    end else if (grant1_s) begin
      ptr_r <= 1'b0;
      cnt_r <= cnt_r + 16'd1;
    end else begin
      ptr_r <= ptr_r;
      cnt_r <= cnt_r;
    end
  end

  // Slot 0 capture and drain. A refill wins over a drain, so the slot stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0_r <= 1'b0;
      data0_r <= 32'd0;
      zero0_r <= 1'b0;
      tag0_r  <= {TAG_W{1'b0}};
    end else if (grant0_s) begin
      full0_r <= 1'b1;
      data0_r <= alu_result;
      zero0_r <= alu_zero;
      tag0_r  <= req0_tag;
    end else if (resp0_ready) begin
      full0_r <= 1'b0;
    end else begin
      full0_r <= full0_r;
    end
  end

  // Slot 1 capture and drain. It follows the same rules as slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full1_r <= 1'b0;
      data1_r <= 32'd0;
      zero1_r <= 1'b0;
      tag1_r  <= {TAG_W{1'b0}};
    end else if (grant1_s) begin
      full1_r <= 1'b1;
      data1_r <= alu_result;
      zero1_r <= alu_zero;
      tag1_r  <= req1_tag;
    end else if (resp1_ready) begin
      full1_r <= 1'b0;
    end else begin
      full1_r <= full1_r;
    end
  end

  assign resp0_valid = full0_r;
  assign resp0_data  = data0_r;
  assign resp0_zero  = zero0_r;
  assign resp0_tag   = tag0_r;
  assign resp1_valid = full1_r;
  assign resp1_data  = data1_r;
  assign resp1_zero  = zero1_r;
  assign resp1_tag   = tag1_r;
  assign grant_cnt   = cnt_r;

endmodule
